// File: rtl/sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : sw_debouncer
// Description : Per-channel 2-FF synchronizer plus tick-sampled stability
//               filter, producing a clean level and one-cycle rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debouncer #(
    parameter int WIDTH      = 1,
    parameter int TICK_DIV   = 1,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W = $clog2(STABLE_CNT);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;
    logic [WIDTH-1:0]   r_filt;
    logic [c_CNT_W-1:0] r_cnt [WIDTH];

    assign w_tick = (r_div == c_DIV_LAST);

    // r_filt is the qualified state; sw_level and the strobes are a registered
    // view of it, so all three outputs change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_div    <= '0;
            r_filt   <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= sw_in;
            r_sync2  <= r_sync1;
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            sw_level <= r_filt;
            sw_rise  <= r_filt & ~sw_level;
            sw_fall  <= ~r_filt & sw_level;
            if (w_tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (r_sync2[i] == r_filt[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == c_CNT_LAST) begin
                        r_filt[i] <= r_sync2[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debouncer
// Description : Self-checking bench for sw_debouncer (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_in;
    logic [1:0] a_lvl, a_rise, a_fall;
    logic [1:0] b_lvl, b_rise, b_fall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_debouncer #(.WIDTH(2), .TICK_DIV(1), .STABLE_CNT(4)) dut_a (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .sw_level(a_lvl), .sw_rise(a_rise), .sw_fall(a_fall)
    );

    sw_debouncer #(.WIDTH(2), .TICK_DIV(4), .STABLE_CNT(3)) dut_b (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .sw_level(b_lvl), .sw_rise(b_rise), .sw_fall(b_fall)
    );

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int         m_n;
    logic [1:0] m_q[$];
    logic [1:0] m_filt[2], m_lvl[2], m_rise[2], m_fall[2];
    int         m_run[2][2];

    function automatic void model_reset();
        m_n = 0;
        m_q.delete();
        for (int d = 0; d < 2; d++) begin
            m_filt[d] = 2'b00; m_lvl[d] = 2'b00; m_rise[d] = 2'b00; m_fall[d] = 2'b00;
            m_run[d][0] = 0; m_run[d][1] = 0;
        end
    endfunction

    task automatic model_edge();
        logic [1:0] s;
        int tdiv, scnt;
        m_n++;
        m_q.push_front(sw_in);
        if (m_q.size() > 3) void'(m_q.pop_back());
        s = (m_q.size() == 3) ? m_q[2] : 2'b00;
        for (int d = 0; d < 2; d++) begin
            tdiv = (d == 0) ? 1 : 4;
            scnt = (d == 0) ? 4 : 3;
            m_rise[d] = m_filt[d] & ~m_lvl[d];
            m_fall[d] = ~m_filt[d] & m_lvl[d];
            m_lvl[d]  = m_filt[d];
            if (m_n % tdiv == 0) begin
                for (int c = 0; c < 2; c++) begin
                    if (s[c] != m_filt[d][c]) begin
                        m_run[d][c]++;
                        if (m_run[d][c] == scnt) begin
                            m_filt[d][c] = s[c];
                            m_run[d][c]  = 0;
                        end
                    end else begin
                        m_run[d][c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives, clocks once, returns at the next negedge.
    task automatic step(input logic [1:0] v);
        sw_in = v;
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        chk("dut_a_vs_model", {a_lvl, a_rise, a_fall}, {m_lvl[0], m_rise[0], m_fall[0]});
        chk("dut_b_vs_model", {b_lvl, b_rise, b_fall}, {m_lvl[1], m_rise[1], m_fall[1]});
        chk("a_strobe_excl", a_rise & a_fall, 0);
        if (reset) chk("b_tick_phase", dut_b.w_tick, ((m_n + 1) % 4 == 0));
    endtask

    task automatic do_reset(input logic [1:0] v, input int cycles);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) step(v);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0] sw;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        int         n;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int first;
        // clean step up and down, short glitch, 3/1/3 bounce, then independence
        tbl.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 6});
        tbl.push_back('{2'b01, 2'b01, 2'b01, 2'b00, 1});
        tbl.push_back('{2'b01, 2'b01, 2'b00, 2'b00, 1});
        tbl.push_back('{2'b00, 2'b01, 2'b00, 2'b00, 6});
        tbl.push_back('{2'b00, 2'b00, 2'b00, 2'b01, 1});
        tbl.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1});
        tbl.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 3});
        tbl.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 6});
        tbl.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 3});
        tbl.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 1});
        tbl.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 3});
        tbl.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 6});
        tbl.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 2});
        tbl.push_back('{2'b11, 2'b00, 2'b00, 2'b00, 4});
        tbl.push_back('{2'b11, 2'b01, 2'b01, 2'b00, 1});
        tbl.push_back('{2'b11, 2'b01, 2'b00, 2'b00, 1});
        tbl.push_back('{2'b11, 2'b11, 2'b10, 2'b00, 1});
        tbl.push_back('{2'b11, 2'b11, 2'b00, 2'b00, 1});

        sw_in = 2'b00;
        reset = 1'b0;
        model_reset();

        // Reset held with inputs high, then qualification from scratch
        for (int i = 0; i < 5; i++) begin
            step(2'b11);
            chk("rst_hold_outputs", {a_lvl, a_rise, a_fall}, 0);
        end
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(2'b11);
            chk($sformatf("rst_release_e%0d", e), a_lvl, (e >= 7) ? 2'b11 : 2'b00);
        end

        // Table-driven vectors from a clean state
        do_reset(2'b00, 2);
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                step(tbl[i].sw);
                chk($sformatf("vec%0d_%0d", i, r), {a_lvl, a_rise, a_fall},
                    {tbl[i].lvl, tbl[i].rise, tbl[i].fall});
            end
        end

        // Prescaled instance: rise must land inside the latency window
        do_reset(2'b00, 2);
        first = -1;
        for (int e = 1; e <= 20; e++) begin
            step(2'b01);
            if (first < 0 && b_lvl[0]) first = e;
        end
        chk("b_rise_in_window_12_15", (first >= 12 && first <= 15), 1);

        // Async reset in the middle of a rising qualification
        do_reset(2'b00, 2);
        for (int i = 0; i < 8; i++) step(2'b10);
        for (int i = 0; i < 4; i++) step(2'b11);
        chk("mid_cnt_before_reset", dut_a.r_cnt[0], 2);
        chk("mid_level_before_reset", a_lvl, 2'b10);
        reset = 1'b0;
        #1;
        chk("async_reset_a", {a_lvl, a_rise, a_fall}, 0);
        chk("async_reset_b", {b_lvl, b_rise, b_fall}, 0);
        model_reset();
        @(negedge clk);
        step(2'b11);
        step(2'b11);
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(2'b11);
            chk($sformatf("requal_e%0d", e), a_lvl, (e >= 7) ? 2'b11 : 2'b00);
        end

        // Random bouncing inputs against the model
        for (int s = 0; s < 250; s++) begin
            logic [1:0] v;
            int hold;
            v = 2'($urandom);
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) step(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
